// File: rtl/seg_scan.sv
// seg_scan: 4-digit common-anode seven-segment scanner with blanking gap and hex decode.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits 3..1 at each frame load.
module seg_scan #(
    parameter int SHOW_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_start
);
    localparam int MAXC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [6:0] SEG_LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    typedef enum logic {BLANK, SHOW} state_t;
    state_t          r_state, w_state_n;
    logic [CW-1:0]   r_cnt, w_cnt_n;
    logic [1:0]      r_idx, w_idx_n;
    logic            w_load;
    logic [15:0]     r_dig;
    logic [3:0]      r_dp, r_en, w_en_load;
    logic [3:0]      w_nib;
    logic            w_on;
`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0]      w_lz;
    assign w_lz      = {digits[15:12] == '0, digits[15:8] == '0, digits[15:4] == '0, 1'b0};
    assign w_en_load = digit_en & ~w_lz;
`else
    assign w_en_load = digit_en;
`endif
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt + 1'b1;
        w_idx_n   = r_idx;
        w_load    = 1'b0;
        if (r_state == BLANK) begin
            if (r_cnt == CW'(BLANK_CYCLES - 1)) begin
                w_state_n = SHOW;
                w_cnt_n   = '0;
                w_load    = (r_idx == 2'd0);
            end
        end else if (r_cnt == CW'(SHOW_CYCLES - 1)) begin
            w_state_n = BLANK;
            w_cnt_n   = '0;
            w_idx_n   = r_idx + 2'd1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_dig   <= '0;
            r_dp    <= '0;
            r_en    <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            if (w_load) begin
                r_dig <= digits;
                r_dp  <= dp_in;
                r_en  <= w_en_load;
            end
        end
    end
    // outputs lag the state by one clock so every output is a flop
    assign w_nib = r_dig[{r_idx, 2'b00} +: 4];
    assign w_on  = (r_state == SHOW) && r_en[r_idx];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an          <= 4'b1111;
            seg         <= 7'b1111111;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= w_on ? ~(4'b0001 << r_idx) : 4'b1111;
            seg         <= w_on ? SEG_LUT[w_nib] : 7'b1111111;
            dp          <= w_on ? ~r_dp[r_idx] : 1'b1;
            frame_start <= (r_state == SHOW) && (r_cnt == '0) && (r_idx == 2'd0);
        end
    end
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: randomized scoreboard bench for seg_scan against a frame/slot timing model.
module tb_seg_scan;
    localparam int SC = 8, BC = 2, DPER = SC + BC, FP = 4 * DPER;
    typedef struct packed {logic [3:0] an; logic [6:0] seg; logic dp; logic fs;} out_t;
    localparam logic [6:0] LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam out_t BLANK_OUT = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fs: 1'b0};
    logic clk = 0, rst = 0;
    logic [15:0] digits = '0;
    logic [3:0]  dp_in = '0, digit_en = '0;
    logic [6:0]  seg;
    logic        dp, frame_start;
    logic [3:0]  an;
    out_t        exp_q[$];
    int          n_tests = 0, n_fail = 0;
    logic [15:0] s_dig;
    logic [3:0]  s_dp, s_en;

    seg_scan #(.SHOW_CYCLES(SC), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst(rst), .digits(digits), .dp_in(dp_in), .digit_en(digit_en),
        .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Cycle k's output: slot = (k mod frame)/digit period, lit after the blank gap, using the frame snapshot.
    function automatic out_t model(int k);
        int p = k % FP;
        int d = p / DPER;
        logic lit;
        out_t o;
        o = BLANK_OUT;
        o.fs = (p == BC);
        lit = ((p % DPER) >= BC) && s_en[d];
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && (s_dig >> (4 * d)) == 16'h0) lit = 1'b0;
`endif
        if (lit) begin
            o.an  = 4'hF ^ (4'h1 << d);
            o.seg = LUT[s_dig[4*d +: 4]];
            o.dp  = ~s_dp[d];
        end
        return o;
    endfunction

    task automatic check(string name, out_t got, out_t e);
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s @%0t: got an=%b seg=%b dp=%b fs=%b, expected an=%b seg=%b dp=%b fs=%b",
                     name, $time, got.an, got.seg, got.dp, got.fs, e.an, e.seg, e.dp, e.fs);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) check("scan", {an, seg, dp, frame_start}, exp_q.pop_front());
    end

    task automatic stim(int scen, int k);
        case (scen)
            0: begin
                if (k == 0) begin digits = 16'h1234; dp_in = 4'b0001; digit_en = 4'b1111; end
                if (k == 15) digits = 16'hFFFF;
            end
            1: if (k == 0) begin digits = 16'h1234; dp_in = 4'b0000; digit_en = 4'b1010; end
            2: if (k == 0) begin digits = 16'h0050; dp_in = 4'($urandom); digit_en = 4'b1111; end
            default: if (k == 0 || $urandom_range(7) == 0) begin
                digits   = 16'($urandom) >> (4 * $urandom_range(3));
                dp_in    = 4'($urandom);
                digit_en = ($urandom_range(1) == 0) ? 4'hF : 4'($urandom);
            end
        endcase
    endtask

    task automatic run(int scen, int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            stim(scen, k);
            if (k % FP == 1) begin s_dig = digits; s_dp = dp_in; s_en = digit_en; end
            exp_q.push_back(model(k));
            @(negedge clk);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic mid_reset();
        #2 rst = 1;
        digits = 16'($urandom);
        #1 check("async_rst", {an, seg, dp, frame_start}, BLANK_OUT);
        @(posedge clk);
        #1 check("rst_hold", {an, seg, dp, frame_start}, BLANK_OUT);
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        #1 rst = 1;
        digits = 16'($urandom); dp_in = 4'hF; digit_en = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset", {an, seg, dp, frame_start}, BLANK_OUT);
        end
        rst = 0;
        run(0, 3 * FP + 5);
        mid_reset();
        run(1, 2 * FP + 5);
        mid_reset();
        run(2, FP + 5);
        mid_reset();
        run(3, 6 * FP + 5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Time-multiplexed driver for the board's 4-digit common-anode seven-segment display.
- Sits downstream of the switch/decoder datapath and replaces the fixed single-digit anode drive with a rotating scan.
- Takes four hex nibbles plus decimal-point bits and refreshes one digit at a time with built-in hex-to-segment decode.
- Inserts an all-off blanking gap between digits to suppress ghosting.

Parameters:
- SHOW_CYCLES, 100000, clocks each digit is lit (1 ms at 100 MHz); must be >= 1.
- BLANK_CYCLES, 1000, clocks all anodes are off before each digit; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- digits  input  16  hex digits; [3:0] is digit 0 (rightmost, an[0]) through [15:12] for digit 3.
- dp_in  input  4  decimal point request per digit, 1 = lit.
- digit_en  input  4  per-digit enable, 1 = displayed.
- seg  output  7  segments, active-low; seg[0]=a through seg[6]=g.
- dp  output  1  decimal point, active-low.
- an  output  4  anodes, active-low.
- frame_start  output  1  one-cycle pulse when digit 0 begins SHOW.

Behaviour:
- Reset (async, immediate):
  - an=4'b1111, seg=7'b1111111, dp=1, frame_start=0.
  - state=BLANK, idx=0, phase counter=0, shadow registers=0.
- All outputs are registered.
- FSM states are BLANK and SHOW. The phase counter counts 0..N-1 in each state.
- BLANK:
  - an=1111, seg=1111111, dp=1.
  - When counter==BLANK_CYCLES-1: go to SHOW and clear the counter.
  - If idx==0, load the shadow registers from digits/dp_in/digit_en on that same edge.
- SHOW:
  - an[idx]=0 and the other anodes are 1.
  - seg=decode(shadow nibble idx); dp=~shadow_dp[idx].
  - When counter==SHOW_CYCLES-1: go to BLANK, idx=(idx+1) mod 4 (3 wraps to 0), clear the counter.
- Disabled digit (shadow_en[idx]=0):
  - SHOW timing is unchanged.
  - an stays 1111, seg=1111111, dp=1.
  - The refresh rate never depends on the enables.
- frame_start is 1 for exactly the first SHOW cycle of idx 0 and is 0 otherwise.
- Period per digit is BLANK_CYCLES+SHOW_CYCLES. Frame period is 4x that.
- After rst deasserts, the first BLANK of digit 0 starts on the first clock edge.
- Input changes during a frame are not visible until the next shadow load, so a frame always shows one coherent value.
- Decode table (seg[6:0], active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Reset asserted mid-SHOW or mid-BLANK: outputs blank at once. After release, the sequence restarts from BLANK of digit 0 with the shadow cleared.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - At shadow load, each digit k in 3..1 is marked blank when its nibble and all higher nibbles are 0.
  - A blank digit behaves as disabled, including suppressing dp.
  - Digit 0 is never blanked by this rule.
- Undefined: no zero suppression; only digit_en gates digits.

Test Plan:
- All tests use SHOW_CYCLES=8, BLANK_CYCLES=2. Cycle 0 is the first edge after rst release.
- Reset: hold rst=1 with any inputs -> an=1111, seg=1111111, dp=1, frame_start=0. Toggle rst mid-stream -> outputs blank in the same cycle, without waiting for a clock edge.
- Scan order: digits=16'h1234, dp_in=0001, digit_en=1111 ->
  - cycles 0-1 blank.
  - cycles 2-9: an=1110, seg=0011001, dp=0.
  - cycles 10-11 blank.
  - cycles 12-19: an=1101, seg=0110000, dp=1.
  - 22-29: an=1011, seg=0100100.
  - 32-39: an=0111, seg=1111001.
  - frame_start=1 only at cycles 2 and 42.
- Coherence: change digits to 16'hFFFF at cycle 15 -> digits 1-3 still show 3,2,1 in this frame. Cycle 42 onward shows seg=0001110 on every digit.
- Enable gating: digit_en=1010 -> an=1111 during cycles 2-9 and 22-29. Digits 1 and 3 are shown on schedule and frame_start timing is unchanged.
- Wrap: run 3 frames -> idx sequence 0,1,2,3,0,... with no gap or extra cycle at 3->0. Frame period is exactly 40 cycles.
- LEADING_ZERO_BLANK_EN, digits=16'h0050:
  - Defined -> digits 3 and 2 keep an=1111; digit 1 shows 0010010; digit 0 shows 1000000.
  - Undefined -> all four digits are lit, showing 0,0,5,0.
